// File: rtl/cache_pkg.sv
// Shared types for the cache controller: sequencing states and memory operation kinds.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        VICTIM    = 3'd2,
        WB_REQ    = 3'd3,
        WB_DATA   = 3'd4,
        FILL_REQ  = 3'd5,
        FILL_DATA = 3'd6,
        INSTALL   = 3'd7
    } ctrl_state_e;

    typedef enum logic {
        FILL      = 1'b0,
        WRITEBACK = 1'b1
    } mem_op_e;

endpackage

// File: rtl/cache_controller_beat_counter.sv
// Beat counter for line transfers; wraps to zero after the last beat of a line.
module beat_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    logic [WIDTH-1:0] count_r;

    // Beat position within the current transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (advance) begin
            count_r <= count_r + WIDTH'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign last  = &count_r;

endmodule

// File: rtl/cache_controller.sv
// Cache sequencing FSM: resolves hits in one lookup, handles misses by
// victim writeback, line fill, install and lookup replay.
module cache_controller
    import cache_pkg::*;
#(
    parameter bit  READ_ONLY      = 1'b0,
    parameter int  WORDS_PER_LINE = 4,
    localparam int WORD_IDX_SIZE  = $clog2(WORDS_PER_LINE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_req_valid,
    input  logic                     cpu_req_write,
    output logic                     cpu_req_ready,
    output logic                     cpu_resp_valid,
    input  logic                     valid_block_match,
    input  logic                     valid_dirty_bit,
    output logic                     miss_recovery_mode,
    output logic                     process_lru_counters,
    output logic                     clear_selected_valid_bit,
    output logic                     finish_new_line_install,
    output logic                     clear_selected_dirty_bit,
    output logic                     set_selected_dirty_bit,
    output logic                     data_we_cpu,
    output logic                     data_we_fill,
    output logic [WORD_IDX_SIZE-1:0] word_index,
    output logic                     mem_req_valid,
    output logic                     mem_req_write,
    output logic                     mem_addr_victim,
    input  logic                     mem_req_ready,
    output logic                     mem_wvalid,
    input  logic                     mem_wready,
    input  logic                     mem_rvalid
);

    ctrl_state_e state_r;
    mem_op_e     mem_op_s;
    logic        last_s;
    logic        clear_s;
    logic        advance_s;
    logic        store_s;
    logic        victim_dirty_s;

    // An instruction-cache build never stores and never sees a dirty victim.
    assign store_s        = cpu_req_write & ~READ_ONLY;
    assign victim_dirty_s = valid_dirty_bit & ~READ_ONLY;

    assign clear_s   = (state_r == IDLE) | (state_r == WB_REQ) | (state_r == FILL_REQ);
    assign advance_s = ((state_r == WB_DATA) & mem_wready) | ((state_r == FILL_DATA) & mem_rvalid);

    beat_counter #(
        .WIDTH (WORD_IDX_SIZE)
    ) u_beat_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_s),
        .advance (advance_s),
        .count   (word_index),
        .last    (last_s)
    );

    // Request sequencing state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE:      state_r <= cpu_req_valid ? LOOKUP : IDLE;
                LOOKUP:    state_r <= valid_block_match ? IDLE : VICTIM;
                VICTIM:    state_r <= victim_dirty_s ? WB_REQ : FILL_REQ;
                WB_REQ:    state_r <= mem_req_ready ? WB_DATA : WB_REQ;
                WB_DATA:   state_r <= (mem_wready & last_s) ? FILL_REQ : WB_DATA;
                FILL_REQ:  state_r <= mem_req_ready ? FILL_DATA : FILL_REQ;
                FILL_DATA: state_r <= (mem_rvalid & last_s) ? INSTALL : FILL_DATA;
                INSTALL:   state_r <= LOOKUP;
                default:   state_r <= IDLE;
            endcase
        end
    end

    // Control strobes decoded from the current state and handshake inputs.
    always_comb begin
        cpu_req_ready            = 1'b0;
        cpu_resp_valid           = 1'b0;
        miss_recovery_mode       = 1'b0;
        process_lru_counters     = 1'b0;
        clear_selected_valid_bit = 1'b0;
        finish_new_line_install  = 1'b0;
        clear_selected_dirty_bit = 1'b0;
        set_selected_dirty_bit   = 1'b0;
        data_we_cpu              = 1'b0;
        data_we_fill             = 1'b0;
        mem_req_valid            = 1'b0;
        mem_addr_victim          = 1'b0;
        mem_wvalid               = 1'b0;
        mem_op_s                 = FILL;
        case (state_r)
            IDLE: begin
                cpu_req_ready = 1'b1;
            end
            LOOKUP: begin
                process_lru_counters   = valid_block_match;
                cpu_resp_valid         = valid_block_match;
                set_selected_dirty_bit = valid_block_match & store_s;
                data_we_cpu            = valid_block_match & store_s;
            end
            VICTIM: begin
                miss_recovery_mode       = 1'b1;
                clear_selected_valid_bit = ~victim_dirty_s;
            end
            WB_REQ: begin
                miss_recovery_mode = 1'b1;
                mem_req_valid      = 1'b1;
                mem_op_s           = WRITEBACK;
                mem_addr_victim    = 1'b1;
            end
            WB_DATA: begin
                miss_recovery_mode       = 1'b1;
                mem_wvalid               = 1'b1;
                mem_addr_victim          = 1'b1;
                clear_selected_dirty_bit = mem_wready & last_s & ~READ_ONLY;
                clear_selected_valid_bit = mem_wready & last_s;
            end
            FILL_REQ: begin
                miss_recovery_mode = 1'b1;
                mem_req_valid      = 1'b1;
                mem_op_s           = FILL;
            end
            FILL_DATA: begin
                miss_recovery_mode = 1'b1;
                data_we_fill       = mem_rvalid;
            end
            INSTALL: begin
                miss_recovery_mode      = 1'b1;
                finish_new_line_install = 1'b1;
            end
            default: begin
                cpu_req_ready = 1'b1;
            end
        endcase
    end

    assign mem_req_write = (mem_op_s == WRITEBACK);

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
Sequencing FSM that drives the cache metadata block's control inputs and consumes its hit/dirty status.
- Accepts one CPU request at a time and resolves hits in one lookup cycle.
- On a miss it selects the LRU victim, writes it back if dirty, fills the line word-by-word from memory, installs it, then replays the lookup.
- Sits between the CPU port, the metadata/data arrays and the memory port of one cache instance.

Parameters:
READ_ONLY, 0, 1 = instruction-cache build; no writes, no dirty handling, writeback states unreachable
WORDS_PER_LINE, 4, memory beats per line transfer; power of two, >= 2
WORD_IDX_SIZE, $clog2(WORDS_PER_LINE), derived localparam; beat index width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
cpu_req_valid  input  1  CPU request present; address/op held stable by CPU until cpu_resp_valid
cpu_req_write  input  1  1 = store, 0 = load
cpu_req_ready  output  1  high only in IDLE
cpu_resp_valid  output  1  one-cycle pulse: request complete, read data valid / write data committed
valid_block_match  input  1  from metadata: lookup hit
valid_dirty_bit  input  1  from metadata: selected way is valid and dirty
miss_recovery_mode  output  1  to metadata: select victim way instead of matching way
process_lru_counters  output  1  to metadata: mark selected way MRU
clear_selected_valid_bit  output  1  to metadata
finish_new_line_install  output  1  to metadata: set valid, write tag
clear_selected_dirty_bit  output  1  to metadata
set_selected_dirty_bit  output  1  to metadata
data_we_cpu  output  1  data-array write of CPU store word
data_we_fill  output  1  data-array write of fill beat at word_index
word_index  output  WORD_IDX_SIZE  beat counter value, used for fill and writeback addressing
mem_req_valid  output  1  memory line request
mem_req_write  output  1  1 = writeback, 0 = fill
mem_addr_victim  output  1  1 = line address from selected_tag, 0 = from CPU tag
mem_req_ready  input  1  memory accepts request
mem_wvalid  output  1  writeback beat valid
mem_wready  input  1  writeback beat accepted
mem_rvalid  input  1  fill beat valid; memory never stalled on the read-data path

Behaviour:
- States: IDLE, LOOKUP, VICTIM, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA, INSTALL.
- Registers: state and beat counter only. All outputs decode combinationally from state plus inputs.
- Reset, asynchronous: state=IDLE, counter=0. Every output is 0 except cpu_req_ready=1. Reset mid-transfer abandons the transfer; the memory side must tolerate this.
- IDLE: cpu_req_ready=1. On cpu_req_valid go to LOOKUP.
- LOOKUP, with miss_recovery_mode=0:
  - Hit: process_lru_counters=1 and cpu_resp_valid=1. If cpu_req_write and !READ_ONLY, also set_selected_dirty_bit=1 and data_we_cpu=1. Next state IDLE. Hit latency is 2 cycles from acceptance.
  - Miss: go to VICTIM.
- VICTIM, with miss_recovery_mode=1:
  - valid_dirty_bit=1: go to WB_REQ.
  - Otherwise: clear_selected_valid_bit=1, go to FILL_REQ.
- miss_recovery_mode=1 in VICTIM, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA and INSTALL; 0 elsewhere.
- WB_REQ: mem_req_valid=1, mem_req_write=1, mem_addr_victim=1. On mem_req_ready go to WB_DATA with counter=0.
- WB_DATA: mem_wvalid=1, word_index=counter, mem_addr_victim=1.
  - On mem_wready, counter increments.
  - On mem_wready with counter==WORDS_PER_LINE-1: clear_selected_dirty_bit=1, clear_selected_valid_bit=1, counter wraps to 0, go to FILL_REQ.
- FILL_REQ: mem_req_valid=1, mem_req_write=0, mem_addr_victim=0. On mem_req_ready go to FILL_DATA.
- FILL_DATA: on mem_rvalid, data_we_fill=1 and counter increments. The last beat wraps the counter to 0 and goes to INSTALL.
- INSTALL: finish_new_line_install=1 for one cycle, then LOOKUP.
  - The replay is guaranteed to hit; it updates LRU and sets dirty on a store.
  - This is the sole path to cpu_resp_valid after a miss.
- mem_req_valid stays asserted until mem_req_ready; the request is never withdrawn except by reset.
- READ_ONLY=1:
  - cpu_req_write is ignored.
  - set_selected_dirty_bit, clear_selected_dirty_bit and data_we_cpu are tied 0.
  - VICTIM always takes the clean path.
- Never asserted together: clear_selected_valid_bit with finish_new_line_install, and set_selected_dirty_bit with clear_selected_dirty_bit.

Decomposition:
- Shared package cache_pkg holds:
  - ctrl_state_e enum: the 8 states above.
  - mem_op_e: FILL=0, WRITEBACK=1.
- One sub-module, beat_counter (parameter WIDTH): inputs clk, reset, clear, advance; outputs count and last (count==2**WIDTH-1); wraps to 0.

Test Plan:
- Read hit: metadata returns match=1 in LOOKUP -> cpu_resp_valid and process_lru_counters pulse in cycle 2 after acceptance, no memory traffic.
- Clean read miss, WORDS_PER_LINE=4, mem_req_ready after 3 cycles, rvalid every other cycle:
  - clear_selected_valid_bit pulses once in VICTIM.
  - Exactly 4 data_we_fill pulses with word_index 0,1,2,3.
  - finish_new_line_install pulses once.
  - Replayed LOOKUP hits and cpu_resp_valid pulses.
- Dirty write miss:
  - 4 mem_wvalid beats with mem_addr_victim=1.
  - mem_wready held low 2 cycles on beat 2: word_index holds at 2.
  - Last beat pulses clear_selected_dirty_bit and clear_selected_valid_bit together.
  - Fill follows; replay asserts set_selected_dirty_bit and data_we_cpu.
- READ_ONLY=1, cpu_req_write=1 on a hit -> no set_selected_dirty_bit and no data_we_cpu; valid_dirty_bit forced 1 in VICTIM still takes FILL_REQ.
- Reset asserted asynchronously mid-FILL_DATA at beat 2 -> outputs drop immediately (cpu_req_ready=1, all others 0); counter=0; the next request starts a fresh miss with word_index=0.
- Back-to-back hits with cpu_req_valid held -> one request accepted every 2 cycles; cpu_req_ready low during LOOKUP.
